// File: rtl/regfile8_onehot_if.sv
// Write/read bus between the write-select decoder, the register file and operand fetch.
// The master modport drives writes and read requests. The slave modport (the register file) returns read data and status.
interface regfile8_onehot_if #(
  parameter int WIDTH = 16
);
  logic [7:0]       we_onehot;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [2:0]       rd_addr_a;
  logic [2:0]       rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             err_clr;
  logic             onehot_err;
  logic [7:0]       wr_count;

  modport master (
    output we_onehot, wr_data, rd_en, rd_addr_a, rd_addr_b, err_clr,
    input  rd_data_a, rd_data_b, onehot_err, wr_count
  );

  modport slave (
    input  we_onehot, wr_data, rd_en, rd_addr_a, rd_addr_b, err_clr,
    output rd_data_a, rd_data_b, onehot_err, wr_count
  );
endinterface

// File: rtl/regfile8_onehot.sv
// 8-entry register file with a one-hot write port and two registered read ports; read latency is 1 cycle with write-first bypass.
// There is no backpressure: writes always complete, and rd_en=0 holds the read outputs. A multi-hot write enable sets a sticky error flag.
module regfile8_onehot #(
  parameter int WIDTH   = 16,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile8_onehot_if.slave    bus
);
  logic [WIDTH-1:0] regs [8];
  logic             wr_multi;
  logic             wr_legal;
  logic [WIDTH-1:0] byp_a;
  logic [WIDTH-1:0] byp_b;

  // x & (x-1) clears the lowest set bit, so any remainder means two or more bits were set
  assign wr_multi = (bus.we_onehot & (bus.we_onehot - 8'd1)) != 8'd0;
  assign wr_legal = (bus.we_onehot != 8'd0) && !wr_multi;

  always_comb begin
    byp_a = regs[bus.rd_addr_a];
    if (wr_legal && bus.we_onehot[bus.rd_addr_a]) byp_a = bus.wr_data;
    if (R0_ZERO && bus.rd_addr_a == 3'd0) byp_a = '0;
  end

  always_comb begin
    byp_b = regs[bus.rd_addr_b];
    if (wr_legal && bus.we_onehot[bus.rd_addr_b]) byp_b = bus.wr_data;
    if (R0_ZERO && bus.rd_addr_b == 3'd0) byp_b = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      bus.rd_data_a  <= '0;
      bus.rd_data_b  <= '0;
      bus.onehot_err <= 1'b0;
      bus.wr_count   <= 8'd0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_legal && bus.we_onehot[i] && !(R0_ZERO && i == 0)) regs[i] <= bus.wr_data;
      end
      // a discarded write to a hardwired-zero r0 still counts as committed
      if (wr_legal) bus.wr_count <= bus.wr_count + 8'd1;
      if (bus.rd_en) begin
        bus.rd_data_a <= byp_a;
        bus.rd_data_b <= byp_b;
      end
      if (wr_multi)         bus.onehot_err <= 1'b1;
      else if (bus.err_clr) bus.onehot_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile8_onehot.sv
// Directed bench for regfile8_onehot: it runs the R0_ZERO=0 and R0_ZERO=1 instances in lockstep against a reference model through a scoreboard queue.
module tb_regfile8_onehot;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile8_onehot_if #(.WIDTH(16)) bus0 ();
  regfile8_onehot_if #(.WIDTH(16)) bus1 ();

  assign bus1.we_onehot = bus0.we_onehot;
  assign bus1.wr_data   = bus0.wr_data;
  assign bus1.rd_en     = bus0.rd_en;
  assign bus1.rd_addr_a = bus0.rd_addr_a;
  assign bus1.rd_addr_b = bus0.rd_addr_b;
  assign bus1.err_clr   = bus0.err_clr;

  regfile8_onehot #(.WIDTH(16), .R0_ZERO(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  regfile8_onehot #(.WIDTH(16), .R0_ZERO(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic [15:0] a [2];
    logic [15:0] b [2];
    logic        e [2];
    logic [7:0]  c [2];
  } exp_t;

  exp_t        sbq [$];
  logic [15:0] mreg [2][8];
  logic [15:0] mrda [2];
  logic [15:0] mrdb [2];
  logic        merr [2];
  logic [7:0]  mcnt [2];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 8; r++) mreg[m][r] = 16'h0;
      mrda[m] = 16'h0;
      mrdb[m] = 16'h0;
      merr[m] = 1'b0;
      mcnt[m] = 8'd0;
    end
  endtask

  function automatic logic [15:0] mval(input int m, input logic [2:0] a, input logic [7:0] we,
                                      input logic [15:0] wd, input logic legal);
    if (m == 1 && a == 3'd0) return 16'h0;
    if (legal && we[a]) return wd;
    return mreg[m][a];
  endfunction

  task automatic step(input logic [7:0] we, input logic [15:0] wd, input logic re,
                      input logic [2:0] aa, input logic [2:0] ab, input logic clr);
    exp_t e;
    logic multi, legal;
    @(negedge clk);
    bus0.we_onehot = we;
    bus0.wr_data   = wd;
    bus0.rd_en     = re;
    bus0.rd_addr_a = aa;
    bus0.rd_addr_b = ab;
    bus0.err_clr   = clr;
    multi = (we & (we - 8'd1)) != 8'd0;
    legal = (we != 8'd0) && !multi;
    for (int m = 0; m < 2; m++) begin
      if (re) begin
        mrda[m] = mval(m, aa, we, wd, legal);
        mrdb[m] = mval(m, ab, we, wd, legal);
      end
      if (legal) begin
        for (int r = 0; r < 8; r++)
          if (we[r] && !(m == 1 && r == 0)) mreg[m][r] = wd;
        mcnt[m] = mcnt[m] + 8'd1;
      end
      if (multi) merr[m] = 1'b1;
      else if (clr) merr[m] = 1'b0;
      e.a[m] = mrda[m];
      e.b[m] = mrdb[m];
      e.e[m] = merr[m];
      e.c[m] = mcnt[m];
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("rd_data_a0", bus0.rd_data_a, e.a[0]);
    chk("rd_data_b0", bus0.rd_data_b, e.b[0]);
    chk("err0", bus0.onehot_err, e.e[0]);
    chk("cnt0", bus0.wr_count, e.c[0]);
    chk("rd_data_a1", bus1.rd_data_a, e.a[1]);
    chk("rd_data_b1", bus1.rd_data_b, e.b[1]);
    chk("err1", bus1.onehot_err, e.e[1]);
    chk("cnt1", bus1.wr_count, e.c[1]);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_a0"}, bus0.rd_data_a, 16'h0);
    chk({tag, "_b0"}, bus0.rd_data_b, 16'h0);
    chk({tag, "_e0"}, bus0.onehot_err, 1'b0);
    chk({tag, "_c0"}, bus0.wr_count, 8'd0);
    chk({tag, "_a1"}, bus1.rd_data_a, 16'h0);
    chk({tag, "_c1"}, bus1.wr_count, 8'd0);
  endtask

  initial begin
    bus0.we_onehot = 8'h0;
    bus0.wr_data   = 16'h0;
    bus0.rd_en     = 1'b0;
    bus0.rd_addr_a = 3'd0;
    bus0.rd_addr_b = 3'd0;
    bus0.err_clr   = 1'b0;
    model_reset();
    #3;
    chk_zero_outputs("reset_init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // write then read register 3
    step(8'h08, 16'hBEEF, 1'b0, 3'd0, 3'd0, 1'b0);
    step(8'h00, 16'h0000, 1'b1, 3'd3, 3'd3, 1'b0);
    chk("wr_rd_beef", bus0.rd_data_a, 16'hBEEF);
    chk("wr_rd_cnt", bus0.wr_count, 8'd1);

    // same-edge bypass on both ports
    step(8'h20, 16'h1111, 1'b0, 3'd0, 3'd0, 1'b0);
    step(8'h20, 16'h2222, 1'b1, 3'd5, 3'd5, 1'b0);
    chk("bypass_a", bus0.rd_data_a, 16'h2222);
    chk("bypass_b", bus0.rd_data_b, 16'h2222);

    // illegal multi-hot write neither writes nor bypasses
    step(8'h04, 16'h00AA, 1'b0, 3'd0, 3'd0, 1'b0);
    step(8'h06, 16'hFFFF, 1'b1, 3'd2, 3'd1, 1'b0);
    chk("illegal_err", bus0.onehot_err, 1'b1);
    chk("illegal_nobyp", bus0.rd_data_a, 16'h00AA);
    step(8'h00, 16'h0000, 1'b1, 3'd2, 3'd1, 1'b0);
    chk("illegal_r2", bus0.rd_data_a, 16'h00AA);
    chk("illegal_r1", bus0.rd_data_b, 16'h0000);
    chk("illegal_cnt", bus0.wr_count, 8'd4);
    step(8'hC0, 16'h1234, 1'b0, 3'd0, 3'd0, 1'b1);
    chk("err_set_wins", bus0.onehot_err, 1'b1);
    step(8'h00, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b1);
    chk("err_clear", bus0.onehot_err, 1'b0);

    // hardwired-zero register 0 (dut1) versus a normal r0 (dut0)
    step(8'h01, 16'h1234, 1'b1, 3'd0, 3'd0, 1'b0);
    chk("r0z_same", bus1.rd_data_a, 16'h0);
    chk("r0n_same", bus0.rd_data_a, 16'h1234);
    step(8'h00, 16'h0000, 1'b1, 3'd0, 3'd0, 1'b0);
    chk("r0z_next", bus1.rd_data_a, 16'h0);
    chk("r0z_cnt", bus1.wr_count, 8'd5);

    // 251 more writes take the counter from 5 through 255 to 0
    for (int i = 0; i < 251; i++)
      step(8'd1 << (i % 8), 16'(i * 16'h0101), 1'b0, 3'd0, 3'd0, 1'b0);
    chk("wrap_cnt0", bus0.wr_count, 8'd0);
    chk("wrap_cnt1", bus1.wr_count, 8'd0);

    // rd_en low holds outputs through an address change and a write to the addressed register
    step(8'h00, 16'h0000, 1'b1, 3'd3, 3'd5, 1'b0);
    step(8'h10, 16'hABCD, 1'b0, 3'd4, 3'd4, 1'b0);
    step(8'h00, 16'h0000, 1'b0, 3'd6, 3'd7, 1'b0);
    step(8'h00, 16'h0000, 1'b1, 3'd4, 3'd4, 1'b0);
    chk("hold_then_read", bus0.rd_data_b, 16'hABCD);

    // asynchronous reset mid-cycle; a write presented during reset is lost
    step(8'h80, 16'h5A5A, 1'b1, 3'd7, 3'd4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_zero_outputs("reset_async");
    bus0.we_onehot = 8'h08;
    bus0.wr_data   = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    bus0.we_onehot = 8'h00;
    rst_n = 1'b1;
    step(8'h00, 16'h0000, 1'b1, 3'd3, 3'd7, 1'b0);
    chk("post_reset_r3", bus0.rd_data_a, 16'h0);
    chk("post_reset_r7", bus0.rd_data_b, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile8_onehot.md
Name: regfile8_onehot

Overview:
- Eight-entry general-purpose register file that sits directly downstream of the 3-to-8 write-select decoder.
- Takes the decoder's 8-bit one-hot write-enable vector plus write data, and serves two synchronous read ports to the operand-fetch stage.
- Provides registered read data with same-cycle write bypass.
- Flags illegal (multi-hot) write-enable vectors as a sticky error.

Parameters:
- WIDTH, 16, data width of each register and of all data ports.
- R0_ZERO, 0, when 1 register 0 is hardwired to zero: writes to it are discarded and reads of it return 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we_onehot  input  8  one-hot write-enable from the decoder; bit i selects register i; all-zero means no write.
- wr_data  input  WIDTH  data written to the selected register.
- rd_en  input  1  read strobe; when 0, both read outputs hold their value.
- rd_addr_a  input  3  read-port A register index.
- rd_addr_b  input  3  read-port B register index.
- rd_data_a  output  WIDTH  registered read data, port A.
- rd_data_b  output  WIDTH  registered read data, port B.
- err_clr  input  1  synchronous clear of onehot_err.
- onehot_err  output  1  sticky flag: a multi-hot write-enable was presented.
- wr_count  output  8  count of committed writes, wraps 255 -> 0.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately regardless of clk):
  - all 8 registers = 0
  - rd_data_a = rd_data_b = 0
  - onehot_err = 0
  - wr_count = 0
  - Reset asserted mid-operation discards any write in that cycle.
  - Release is synchronous-safe: the first edge with rst_n high behaves normally.
- Write legality, evaluated each rising edge:
  - Legal write: we_onehot has exactly one bit set.
  - No-op: we_onehot == 0.
  - Illegal: two or more bits set. No register is written, onehot_err is set to 1, wr_count does not change.
- Committed write: a legal write loads wr_data into register i and increments wr_count by 1 (mod 256).
  - A legal write to register 0 with R0_ZERO=1 is discarded.
  - That discarded write still increments wr_count.
- Reads (latency 1 cycle):
  - On a rising edge with rd_en=1: rd_data_a <= value(rd_addr_a) and rd_data_b <= value(rd_addr_b).
  - With rd_en=0: both outputs hold.
- Bypass rule: value(x) is wr_data if a legal write to register x commits on the same edge; otherwise it is the stored register contents.
  - Write-first semantics: a read issued in the same cycle as a write to the same register returns the new data.
  - With R0_ZERO=1, value(0) is always 0, including under bypass.
  - An illegal (multi-hot) write never bypasses.
- Both ports may address the same register; both then return the identical value.
- onehot_err:
  - Cleared by err_clr=1 on an edge.
  - If err_clr and a new illegal write occur on the same edge, set wins (flag = 1).
- No combinational path from any input to any output; all outputs are flops.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle after writes -> rd_data_a/b, onehot_err and wr_count go to 0 immediately; a subsequent read of any register returns 0.
- Write/read: we_onehot=8'b0000_1000, wr_data=16'hBEEF; next cycle rd_en=1, rd_addr_a=3 -> rd_data_a=16'hBEEF one cycle later, wr_count=1.
- Bypass: register 5 holds 16'h1111; same edge write we_onehot=8'b0010_0000, wr_data=16'h2222 with rd_en=1, rd_addr_a=5, rd_addr_b=5 -> both outputs = 16'h2222 after that edge.
- Illegal write: register 2 = 16'h00AA; present we_onehot=8'b0000_0110, wr_data=16'hFFFF -> onehot_err=1, register 2 still 16'h00AA, register 1 unchanged, wr_count unchanged. Then err_clr=1 concurrent with we_onehot=8'b1100_0000 -> onehot_err stays 1; err_clr=1 alone -> 0.
- R0_ZERO=1: write 16'h1234 with we_onehot=8'b0000_0001, read addr 0 on the same and the next edge -> rd_data_a=0 both times, wr_count incremented by 1.
- Hold and wrap: issue 256 legal writes -> wr_count returns to 0. With rd_en=0, changing rd_addr_a/b and writing the addressed register -> rd_data_a/b unchanged.
